// File: rtl/onehot_monitor.sv
// One-hot classifier for a sampled word, with a saturating error counter
// and a health FSM (IDLE/GOOD/WARN/FAULT) that latches FAULT until clr/reset.
module onehot_monitor #(
  parameter int DATA_WIDTH   = 32,
  parameter int CNT_WIDTH    = 16,
  parameter int FAULT_THRESH = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clr,
  input  logic                          din_valid,
  input  logic [DATA_WIDTH-1:0]         din,
  output logic                          dout_valid,
  output logic                          onehot,
  output logic                          zero,
  output logic                          multi,
  output logic [$clog2(DATA_WIDTH)-1:0] index,
  output logic [CNT_WIDTH-1:0]          err_count,
  output logic [1:0]                    state,
  output logic                          fault
);

  localparam int unsigned IW     = $clog2(DATA_WIDTH);
  localparam logic [7:0]  THRESH = 8'(FAULT_THRESH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_GOOD  = 2'b01,
    ST_WARN  = 2'b10,
    ST_FAULT = 2'b11
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_dout_valid;
  logic                 r_onehot;
  logic                 r_zero;
  logic                 r_multi;
  logic [IW-1:0]        r_index;
  logic [CNT_WIDTH-1:0] r_err_count;
  logic [CNT_WIDTH-1:0] w_err_nxt;
  logic [7:0]           r_consec;
  logic [7:0]           w_consec_nxt;

  logic                 w_seen;
  logic                 w_many;
  logic                 w_onehot;
  logic [IW-1:0]        w_idx;

  // With exactly one bit set, the last hit in the scan is that bit's position.
  always_comb begin
    w_seen = 1'b0;
    w_many = 1'b0;
    w_idx  = '0;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      if (din[i]) begin
        if (w_seen) w_many = 1'b1;
        w_seen = 1'b1;
        w_idx  = i[IW-1:0];
      end
    end
    w_onehot = w_seen && !w_many;
  end

  always_comb begin
    w_consec_nxt = r_consec;
    w_err_nxt    = r_err_count;
    if (din_valid) begin
      if (w_onehot) begin
        w_consec_nxt = '0;
      end else begin
        if (r_consec < THRESH) w_consec_nxt = r_consec + 8'd1;
        if (r_err_count != '1) w_err_nxt = r_err_count + 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (din_valid) begin
      case (r_state)
        ST_IDLE, ST_GOOD, ST_WARN: begin
          if (w_onehot)                    w_state_nxt = ST_GOOD;
          else if (w_consec_nxt >= THRESH) w_state_nxt = ST_FAULT;
          else                             w_state_nxt = ST_WARN;
        end
        default: w_state_nxt = ST_FAULT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clr) r_state <= ST_IDLE;
    else              r_state <= w_state_nxt;
  end

  // Classification still runs under clr; only the counters are forced to zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dout_valid <= 1'b0;
      r_onehot     <= 1'b0;
      r_zero       <= 1'b0;
      r_multi      <= 1'b0;
      r_index      <= '0;
      r_err_count  <= '0;
      r_consec     <= '0;
    end else begin
      r_dout_valid <= din_valid;
      if (din_valid) begin
        r_onehot <= w_onehot;
        r_zero   <= !w_seen;
        r_multi  <= w_many;
        r_index  <= w_onehot ? w_idx : '0;
      end
      if (clr) begin
        r_err_count <= '0;
        r_consec    <= '0;
      end else begin
        r_err_count <= w_err_nxt;
        r_consec    <= w_consec_nxt;
      end
    end
  end

  assign dout_valid = r_dout_valid;
  assign onehot     = r_onehot;
  assign zero       = r_zero;
  assign multi      = r_multi;
  assign index      = r_index;
  assign err_count  = r_err_count;
  assign state      = r_state;
  assign fault      = (r_state == ST_FAULT);

endmodule

// File: tb/tb_onehot_monitor.sv
// Bench for onehot_monitor: two instances (defaults; CNT_WIDTH=4/FAULT_THRESH=1)
// driven in lockstep and compared each cycle against a behavioural model.
module tb_onehot_monitor;

  logic        clk = 1'b0;
  logic        reset, clr, din_valid;
  logic [31:0] din;

  logic        dv_a, oh_a, z_a, m_a, f_a;
  logic [4:0]  idx_a;
  logic [15:0] ec_a;
  logic [1:0]  st_a;
  logic        dv_b, oh_b, z_b, m_b, f_b;
  logic [4:0]  idx_b;
  logic [3:0]  ec_b;
  logic [1:0]  st_b;

  int checks = 0;
  int errors = 0;

  // model state
  logic        e_dv, e_oh, e_z, e_m;
  int          e_idx;
  int          e_err[2];
  int          e_st[2];
  int          e_consec[2];
  int          th[2]   = '{3, 1};
  int          emax[2] = '{65535, 15};

  always #5 clk = ~clk;

  onehot_monitor #(.DATA_WIDTH(32), .CNT_WIDTH(16), .FAULT_THRESH(3)) dut_a (
    .clk(clk), .reset(reset), .clr(clr), .din_valid(din_valid), .din(din),
    .dout_valid(dv_a), .onehot(oh_a), .zero(z_a), .multi(m_a), .index(idx_a),
    .err_count(ec_a), .state(st_a), .fault(f_a));

  onehot_monitor #(.DATA_WIDTH(32), .CNT_WIDTH(4), .FAULT_THRESH(1)) dut_b (
    .clk(clk), .reset(reset), .clr(clr), .din_valid(din_valid), .din(din),
    .dout_valid(dv_b), .onehot(oh_b), .zero(z_b), .multi(m_b), .index(idx_b),
    .err_count(ec_b), .state(st_b), .fault(f_b));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic r, input logic c, input logic v, input logic [31:0] d);
    int ones;
    int pos;
    ones = $countones(d);
    pos  = 0;
    for (int i = 0; i < 32; i++) if (d[i]) pos = i;
    if (r) begin
      e_dv = 0; e_oh = 0; e_z = 0; e_m = 0; e_idx = 0;
      for (int k = 0; k < 2; k++) begin e_err[k] = 0; e_st[k] = 0; e_consec[k] = 0; end
      return;
    end
    e_dv = v;
    if (v) begin
      e_oh  = (ones == 1);
      e_z   = (ones == 0);
      e_m   = (ones >= 2);
      e_idx = (ones == 1) ? pos : 0;
    end
    for (int k = 0; k < 2; k++) begin
      if (c) begin
        e_err[k] = 0; e_consec[k] = 0; e_st[k] = 0;
      end else if (v) begin
        if (ones != 1) begin
          e_err[k]    = (e_err[k] < emax[k]) ? e_err[k] + 1 : emax[k];
          e_consec[k] = (e_consec[k] < th[k]) ? e_consec[k] + 1 : th[k];
        end else begin
          e_consec[k] = 0;
        end
        if (e_st[k] != 3) begin
          if (ones == 1)                e_st[k] = 1;
          else if (e_consec[k] >= th[k]) e_st[k] = 3;
          else                           e_st[k] = 2;
        end
      end
    end
  endtask

  task automatic compare_all();
    check("a_dout_valid", 32'(dv_a), 32'(e_dv));
    check("a_onehot",     32'(oh_a), 32'(e_oh));
    check("a_zero",       32'(z_a),  32'(e_z));
    check("a_multi",      32'(m_a),  32'(e_m));
    check("a_index",      32'(idx_a), 32'(e_idx));
    check("a_err_count",  32'(ec_a), 32'(e_err[0]));
    check("a_state",      32'(st_a), 32'(e_st[0]));
    check("a_fault",      32'(f_a),  32'(e_st[0] == 3));
    check("b_dout_valid", 32'(dv_b), 32'(e_dv));
    check("b_onehot",     32'(oh_b), 32'(e_oh));
    check("b_zero",       32'(z_b),  32'(e_z));
    check("b_multi",      32'(m_b),  32'(e_m));
    check("b_index",      32'(idx_b), 32'(e_idx));
    check("b_err_count",  32'(ec_b), 32'(e_err[1]));
    check("b_state",      32'(st_b), 32'(e_st[1]));
    check("b_fault",      32'(f_b),  32'(e_st[1] == 3));
  endtask

  task automatic step(input logic r, input logic c, input logic v, input logic [31:0] d);
    reset = r; clr = c; din_valid = v; din = d;
    @(posedge clk);
    model(r, c, v, d);
    #1;
    compare_all();
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    case ($urandom_range(0, 3))
      0:       w = 32'h0;
      1:       w = 32'h1 << $urandom_range(0, 31);
      2:       w = $urandom;
      default: w = (32'h1 << $urandom_range(0, 31)) | (32'h1 << $urandom_range(0, 31));
    endcase
    return w;
  endfunction

  initial begin
    logic [31:0] vec35[7];
    vec35 = '{32'h0, 32'h1, 32'h2, 32'h3, 32'h8, 32'hFFFF_FFFF, 32'h0000_8000};
    reset = 1; clr = 0; din_valid = 0; din = '0;

    // reset state
    step(1, 0, 0, 32'h0);
    step(1, 0, 1, 32'h1);

    // classification table
    foreach (vec35[i]) step(0, 0, 1, vec35[i]);
    check("req035_last_index", 32'(idx_a), 32'd15);
    step(0, 0, 0, 32'h3);

    // fault entry
    step(1, 0, 0, 32'h0);
    step(0, 0, 1, 32'h3);
    check("req036_warn1", 32'(st_a), 32'd2);
    step(0, 0, 1, 32'h0);
    step(0, 0, 1, 32'h5);
    check("req036_fault", 32'(f_a), 32'd1);
    check("req036_errc",  32'(ec_a), 32'd3);

    // sticky fault with gaps, then clr
    for (int i = 0; i < 6; i++) step(0, 0, i % 2, 32'h1);
    check("req038_sticky", 32'(st_a), 32'd3);
    step(0, 1, 0, 32'h0);
    check("req038_clr_errc", 32'(ec_a), 32'd0);

    // recovery
    step(1, 0, 0, 32'h0);
    step(0, 0, 1, 32'h3);
    step(0, 0, 1, 32'h4);
    check("req037_good", 32'(st_a), 32'd1);
    step(0, 0, 1, 32'h3);
    step(0, 0, 1, 32'h3);
    check("req037_warn", 32'(st_a), 32'd2);

    // clr collides with a valid sample; then reset mid-WARN with a sample
    step(0, 1, 1, 32'h6);
    check("req039_multi", 32'(m_a), 32'd1);
    step(0, 0, 1, 32'h0);
    step(1, 1, 1, 32'h7);
    check("req039_reset_state", 32'(st_a), 32'd0);

    // saturation on the 4-bit counter
    for (int i = 0; i < 20; i++) step(0, 0, 1, 32'h0);
    check("req040_sat", 32'(ec_b), 32'd15);
    step(0, 0, 1, 32'h0);

    // randomized traffic
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 49) == 0, $urandom_range(0, 19) == 0,
           $urandom_range(0, 3) != 0, rand_word());

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
